// File: rtl/vx_issue_perf_pkg.sv
// Constants and types shared by the issue-stage performance counters.
// The reorder distance width and limit match the issue stage's encoding.
package vx_issue_perf_pkg;

  localparam int PERF_CTR_BITS    = 44;
  localparam int REORDER_DIST_W   = 4;
  localparam int REORDER_DIST_MAX = 15;
  localparam int ALLOC_PERIOD_W   = 64;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_ACTIVE = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/vx_issue_perf_if.sv
// Performance counter bundle.
// The issue block drives the issue-side fields; the memory-side fields belong to another block.
interface vx_issue_perf_if
  import vx_issue_perf_pkg::*;
#(
  parameter int CTR_W = PERF_CTR_BITS
);

  logic [CTR_W-1:0]          ibf_stalls;
  logic [CTR_W-1:0]          nocu_stalls;
  logic [CTR_W-1:0]          rf_reads;
  logic [CTR_W-1:0]          rf_writes;
  logic [CTR_W-1:0]          reorders;
  logic [CTR_W-1:0]          reorder_distances [REORDER_DIST_MAX:1];
  logic [CTR_W-1:0]          cu_util;
  logic [CTR_W-1:0]          rrs_util;
  logic [ALLOC_PERIOD_W-1:0] cu_alloc_period;
  logic [ALLOC_PERIOD_W-1:0] rrs_alloc_period;

  logic [CTR_W-1:0]          ifetches;
  logic [CTR_W-1:0]          loads;
  logic [CTR_W-1:0]          stores;
  logic [CTR_W-1:0]          ifetch_latency;
  logic [CTR_W-1:0]          load_latency;

  modport issue (
    output ibf_stalls, nocu_stalls, rf_reads, rf_writes, reorders, reorder_distances,
           cu_util, rrs_util, cu_alloc_period, rrs_alloc_period
  );

  modport mem (
    output ifetches, loads, stores, ifetch_latency, load_latency
  );

  modport slave (
    input ibf_stalls, nocu_stalls, rf_reads, rf_writes, reorders, reorder_distances,
          cu_util, rrs_util, cu_alloc_period, rrs_alloc_period,
          ifetches, loads, stores, ifetch_latency, load_latency
  );

endinterface

// File: rtl/vx_issue_perf_popcount.sv
// Combinational population count of a busy mask.
module vx_issue_perf_popcount #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     mask,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/vx_issue_perf.sv
// Issue-stage event counters: inputs registered in one stage, counters updated in the next,
// so an event is visible two cycles after it is presented. perf_clear and reset both zero everything.
module vx_issue_perf
  import vx_issue_perf_pkg::*;
#(
  parameter int NUM_CUS = 4,
  parameter int NUM_RRS = 8,
  parameter int CTR_W   = PERF_CTR_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      perf_clear,
  input  logic                      ibf_stall,
  input  logic                      nocu_stall,
  input  logic [1:0]                rf_read_cnt,
  input  logic                      rf_write,
  input  logic                      reorder_valid,
  input  logic [REORDER_DIST_W-1:0] reorder_dist,
  input  logic [NUM_CUS-1:0]        cu_busy,
  input  logic [NUM_RRS-1:0]        rrs_busy,
  vx_issue_perf_if.issue            perf_issue_if
);

  localparam int CU_CNT_W  = $clog2(NUM_CUS + 1);
  localparam int RRS_CNT_W = $clog2(NUM_RRS + 1);

  logic clr;
  assign clr = reset | perf_clear;

  // Stage p0: registered events; a zero reorder distance is dropped here.
  logic                      ibf_stall_p0;
  logic                      nocu_stall_p0;
  logic [1:0]                rf_read_cnt_p0;
  logic                      rf_write_p0;
  logic                      reorder_vld_p0;
  logic [REORDER_DIST_W-1:0] reorder_dist_p0;
  logic [NUM_CUS-1:0]        cu_busy_p0;
  logic [NUM_RRS-1:0]        rrs_busy_p0;

  always_ff @(posedge clk) begin
    if (clr) begin
      ibf_stall_p0    <= 1'b0;
      nocu_stall_p0   <= 1'b0;
      rf_read_cnt_p0  <= '0;
      rf_write_p0     <= 1'b0;
      reorder_vld_p0  <= 1'b0;
      reorder_dist_p0 <= '0;
      cu_busy_p0      <= '0;
      rrs_busy_p0     <= '0;
    end else begin
      ibf_stall_p0    <= ibf_stall;
      nocu_stall_p0   <= nocu_stall;
      rf_read_cnt_p0  <= rf_read_cnt;
      rf_write_p0     <= rf_write;
      reorder_vld_p0  <= reorder_valid && (reorder_dist != '0);
      reorder_dist_p0 <= reorder_dist;
      cu_busy_p0      <= cu_busy;
      rrs_busy_p0     <= rrs_busy;
    end
  end

  logic [CU_CNT_W-1:0]  cu_pop_p0;
  logic [RRS_CNT_W-1:0] rrs_pop_p0;

  vx_issue_perf_popcount #(.N(NUM_CUS), .CNT_W(CU_CNT_W)) u_cu_popcount (
    .mask  (cu_busy_p0),
    .count (cu_pop_p0)
  );

  vx_issue_perf_popcount #(.N(NUM_RRS), .CNT_W(RRS_CNT_W)) u_rrs_popcount (
    .mask  (rrs_busy_p0),
    .count (rrs_pop_p0)
  );

  alloc_state_e cu_state, cu_state_nxt;
  alloc_state_e rrs_state, rrs_state_nxt;

  always_comb begin
    cu_state_nxt  = cu_state;
    rrs_state_nxt = rrs_state;
    case (cu_state)
      ALLOC_IDLE:   if (cu_busy_p0 != '0) cu_state_nxt = ALLOC_ACTIVE;
      ALLOC_ACTIVE: if (cu_busy_p0 == '0) cu_state_nxt = ALLOC_IDLE;
      default:      cu_state_nxt = ALLOC_IDLE;
    endcase
    case (rrs_state)
      ALLOC_IDLE:   if (rrs_busy_p0 != '0) rrs_state_nxt = ALLOC_ACTIVE;
      ALLOC_ACTIVE: if (rrs_busy_p0 == '0) rrs_state_nxt = ALLOC_IDLE;
      default:      rrs_state_nxt = ALLOC_IDLE;
    endcase
  end

  // Stage p1: counters; alloc periods count every cycle whose resulting state is ACTIVE.
  logic [CTR_W-1:0]          ibf_stalls_p1;
  logic [CTR_W-1:0]          nocu_stalls_p1;
  logic [CTR_W-1:0]          rf_reads_p1;
  logic [CTR_W-1:0]          rf_writes_p1;
  logic [CTR_W-1:0]          reorders_p1;
  logic [CTR_W-1:0]          reorder_dist_ctr_p1 [REORDER_DIST_MAX:1];
  logic [CTR_W-1:0]          cu_util_p1;
  logic [CTR_W-1:0]          rrs_util_p1;
  logic [ALLOC_PERIOD_W-1:0] cu_alloc_period_p1;
  logic [ALLOC_PERIOD_W-1:0] rrs_alloc_period_p1;

  always_ff @(posedge clk) begin
    if (clr) begin
      cu_state            <= ALLOC_IDLE;
      rrs_state           <= ALLOC_IDLE;
      ibf_stalls_p1       <= '0;
      nocu_stalls_p1      <= '0;
      rf_reads_p1         <= '0;
      rf_writes_p1        <= '0;
      reorders_p1         <= '0;
      reorder_dist_ctr_p1 <= '{default: '0};
      cu_util_p1          <= '0;
      rrs_util_p1         <= '0;
      cu_alloc_period_p1  <= '0;
      rrs_alloc_period_p1 <= '0;
    end else begin
      cu_state            <= cu_state_nxt;
      rrs_state           <= rrs_state_nxt;
      ibf_stalls_p1       <= ibf_stalls_p1 + CTR_W'(ibf_stall_p0);
      nocu_stalls_p1      <= nocu_stalls_p1 + CTR_W'(nocu_stall_p0);
      rf_reads_p1         <= rf_reads_p1 + CTR_W'(rf_read_cnt_p0);
      rf_writes_p1        <= rf_writes_p1 + CTR_W'(rf_write_p0);
      cu_util_p1          <= cu_util_p1 + CTR_W'(cu_pop_p0);
      rrs_util_p1         <= rrs_util_p1 + CTR_W'(rrs_pop_p0);
      cu_alloc_period_p1  <= cu_alloc_period_p1 + ALLOC_PERIOD_W'(cu_state_nxt == ALLOC_ACTIVE);
      rrs_alloc_period_p1 <= rrs_alloc_period_p1 + ALLOC_PERIOD_W'(rrs_state_nxt == ALLOC_ACTIVE);
      if (reorder_vld_p0) begin
        reorders_p1 <= reorders_p1 + CTR_W'(1);
        reorder_dist_ctr_p1[reorder_dist_p0] <= reorder_dist_ctr_p1[reorder_dist_p0] + CTR_W'(1);
      end
    end
  end

  assign perf_issue_if.ibf_stalls        = ibf_stalls_p1;
  assign perf_issue_if.nocu_stalls       = nocu_stalls_p1;
  assign perf_issue_if.rf_reads          = rf_reads_p1;
  assign perf_issue_if.rf_writes         = rf_writes_p1;
  assign perf_issue_if.reorders          = reorders_p1;
  assign perf_issue_if.reorder_distances = reorder_dist_ctr_p1;
  assign perf_issue_if.cu_util           = cu_util_p1;
  assign perf_issue_if.rrs_util          = rrs_util_p1;
  assign perf_issue_if.cu_alloc_period   = cu_alloc_period_p1;
  assign perf_issue_if.rrs_alloc_period  = rrs_alloc_period_p1;

endmodule

// File: doc/vx_issue_perf.md
VX_ISSUE_PERF -- requirements
Module: VX_issue_perf

Interface
REQ-001 SHALL have parameter NUM_CUS, default 4, number of compute units tracked.
REQ-002 SHALL have parameter NUM_RRS, default 8, number of reorder/reservation-station entries tracked.
REQ-003 SHALL have parameter CTR_W, default `PERF_CTR_BITS, width of every event counter output.
REQ-004 SHALL have port clk  input  1  the single clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port perf_clear  input  1  synchronous clear of all counters.
REQ-007 SHALL have port ibf_stall  input  1  instruction-buffer stall this cycle.
REQ-008 SHALL have port nocu_stall  input  1  dispatch stalled because no CU is free.
REQ-009 SHALL have port rf_read_cnt  input  2  register-file reads this cycle, 0..3.
REQ-010 SHALL have port rf_write  input  1  register-file write this cycle.
REQ-011 SHALL have port reorder_valid  input  1  an out-of-order issue occurred.
REQ-012 SHALL have port reorder_dist  input  4  reorder distance, 0..15.
REQ-013 SHALL have port cu_busy  input  NUM_CUS  per-CU allocated mask.
REQ-014 SHALL have port rrs_busy  input  NUM_RRS  per-entry occupied mask.
REQ-015 SHALL have port perf_issue_if  modport issue  drives ibf_stalls, nocu_stalls, rf_reads, rf_writes, reorders, reorder_distances[15:1], cu_util, rrs_util (CTR_W), and cu_alloc_period, rrs_alloc_period (64).

Function
REQ-016 SHALL register all event inputs in an input stage; each counter SHALL update the following cycle; an event sampled in cycle N SHALL be visible on outputs in cycle N+2.
REQ-017 SHALL drive every output directly from a flop.
REQ-018 SHALL increment ibf_stalls, nocu_stalls, and rf_writes by 1 per asserted cycle.
REQ-019 SHALL add rf_read_cnt to rf_reads each cycle.
REQ-020 SHALL, when reorder_valid and reorder_dist in 1..15, increment reorders and reorder_distances[reorder_dist] by 1.
REQ-021 SHALL ignore reorder_valid with reorder_dist=0: no counter changes.
REQ-022 SHALL add popcount(cu_busy) to cu_util each cycle, and popcount(rrs_busy) to rrs_util each cycle.
REQ-023 SHALL implement, for each of CU and RRS, a two-state FSM IDLE/ACTIVE.
  - IDLE->ACTIVE when the registered mask is non-zero; ACTIVE->IDLE when it is zero.
  - The matching *_alloc_period SHALL increment by 1 in every cycle the FSM is ACTIVE, including the cycle of the IDLE->ACTIVE transition.
REQ-024 SHALL wrap all counters modulo 2^width, with no saturation and no sticky flag.
REQ-025 SHALL give perf_clear priority over same-cycle events: those events are dropped, all counters become 0 next cycle, FSMs return to IDLE, and the input-stage registers are cleared.
REQ-026 SHALL leave ifetches, loads, stores, ifetch_latency, load_latency undriven; they are owned by the memory-side perf block.

Reset
REQ-027 SHALL, on reset, zero every output counter and input-stage register and put both FSMs in IDLE; values SHALL be 0 the cycle after reset is sampled high.
REQ-028 SHALL treat reset asserted mid-operation identically to perf_clear, with reset dominating.

Structure
REQ-029 SHALL take the reorder distance width (4) and maximum distance (15) as constants from VX_gpu_pkg, shared with the issue stage.
REQ-030 SHALL use one sub-module, VX_popcount, instantiated twice for the busy masks; all other logic SHALL be flat.

Verification
REQ-031 The bench SHALL apply reorder_valid=1, dist=3 for 5 cycles, then dist=0 for 2 cycles -> reorders=5, reorder_distances[3]=5, all other bins 0.
REQ-032 The bench SHALL apply rf_read_cnt=3 for 4 cycles and rf_write=1 for 2 -> rf_reads=12, rf_writes=2, first change seen 2 cycles after the first event.
REQ-033 The bench SHALL set cu_busy=4'b1011 for 10 cycles, then 0 for 5 -> cu_util=30, cu_alloc_period=10, FSM IDLE after the mask drops.
REQ-034 The bench SHALL preload ibf_stalls to 2^CTR_W-1 (via force or a long run) and apply one more stall -> counter reads 0.
REQ-035 The bench SHALL assert perf_clear in the same cycle as nocu_stall and rrs_busy=8'hFF -> all counters 0, rrs FSM IDLE.
REQ-036 The bench SHALL assert reset mid-run with nonzero counters -> all outputs 0 next cycle; counting resumes correctly after release.
